// File: rtl/ram_master_pkg.sv
// ram_master_pkg: shared constants for the grid RAM master.
//   ADDR_W_DEF / DATA_W_DEF : default grid RAM address / cell widths
//   CLEAR_LAST              : last address visited by the clear sweep
//   ST_*                    : FSM state encodings
package ram_master_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned CLEAR_LAST = 255;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WRITE     = 3'd1;
  localparam logic [2:0] ST_READ_ADDR = 3'd2;
  localparam logic [2:0] ST_READ_DATA = 3'd3;
  localparam logic [2:0] ST_CLEAR     = 3'd4;

endpackage

// File: rtl/ram_sweep_cnt.sv
// ram_sweep_cnt: address counter for the clear sweep.
//   clk_i   : clock (posedge)
//   rst_n_i : synchronous active-low reset
//   en_i    : advance counter by one
//   clr_i   : synchronous return to zero
//   cnt_o   : current sweep address
//   last_o  : counter is at LAST
module ram_sweep_cnt
  import ram_master_pkg::*;
#(
  parameter int unsigned W    = ADDR_W_DEF,
  parameter int unsigned LAST = CLEAR_LAST
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

  assign last_o = (cnt_o == W'(LAST));

endmodule

// File: rtl/ram_master.sv
// ram_master: arbitrates clear / write / read requests onto a single-port
// grid RAM with a shared tri-state data bus.
//   clk_i, rst_n_i          : clock, synchronous active-low reset
//   clr_req_i               : zero every cell (level, sampled in IDLE)
//   wr_req_i/addr/data      : write request, held until wr_ack_o
//   wr_ack_o                : one-cycle write-committed pulse
//   rd_req_i/rd_addr_i      : read request, held until rd_valid_o
//   rd_data_o/rd_valid_o    : read result; data held until next read
//   busy_o                  : FSM not IDLE
//   ram_wr_en_o/ram_rd_en_o : RAM strobes
//   ram_addr_o              : RAM address
//   ram_data_io             : shared RAM data bus
module ram_master
  import ram_master_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_req_i,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ack_o,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              busy_o,
  output logic              ram_wr_en_o,
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  inout  wire  [DATA_W-1:0] ram_data_io
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic [DATA_W-1:0] wr_data_q, rd_data_q;
  logic              rd_valid_q;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              sweep_last;
  logic              bus_drive;
  logic [DATA_W-1:0] bus_data;

  ram_sweep_cnt #(
    .W    (ADDR_W),
    .LAST (CLEAR_LAST)
  ) u_sweep (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (state_q == ST_CLEAR),
    .clr_i   (state_q != ST_CLEAR),
    .cnt_o   (sweep_cnt),
    .last_o  (sweep_last)
  );

  // Every operation returns to IDLE, so the one-cycle bus turnaround falls
  // out of IDLE being the only state that accepts requests.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req_i)     state_d = ST_CLEAR;
        else if (wr_req_i) state_d = ST_WRITE;
        else if (rd_req_i) state_d = ST_READ_ADDR;
      end
      ST_WRITE:     state_d = ST_IDLE;
      ST_READ_ADDR: state_d = ST_READ_DATA;
      ST_READ_DATA: state_d = ST_IDLE;
      ST_CLEAR:     if (sweep_last) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= (state_q == ST_READ_DATA);
      if (state_q == ST_READ_DATA) begin
        rd_data_q <= ram_data_io;
      end
      if (state_q == ST_IDLE && state_d == ST_WRITE) begin
        wr_addr_q <= wr_addr_i;
        wr_data_q <= wr_data_i;
      end
      if (state_q == ST_IDLE && state_d == ST_READ_ADDR) begin
        rd_addr_q <= rd_addr_i;
      end
    end
  end

  always_comb begin
    ram_addr_o = '0;
    case (state_q)
      ST_WRITE:                   ram_addr_o = wr_addr_q;
      ST_READ_ADDR, ST_READ_DATA: ram_addr_o = rd_addr_q;
      ST_CLEAR:                   ram_addr_o = sweep_cnt;
      default:                    ram_addr_o = '0;
    endcase
  end

  assign wr_ack_o    = (state_q == ST_WRITE);
  assign ram_wr_en_o = (state_q == ST_WRITE) || (state_q == ST_CLEAR);
  assign ram_rd_en_o = (state_q == ST_READ_ADDR) || (state_q == ST_READ_DATA);
  assign busy_o      = (state_q != ST_IDLE);
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;

  assign bus_drive   = ram_wr_en_o;
  assign bus_data    = (state_q == ST_WRITE) ? wr_data_q : '0;
  assign ram_data_io = bus_drive ? bus_data : 'z;

endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, grid RAM address width (256 cells).
REQ-002 SHALL have parameter DATA_W, default 4, cell data width.
REQ-003 clk_i  input  1  single clock; all logic on posedge.
REQ-004 rst_n_i  input  1  reset, synchronous, active-low.
REQ-005 clr_req_i  input  1  request to zero all cells; level, sampled in IDLE only.
REQ-006 wr_req_i / wr_addr_i / wr_data_i  input  1 / ADDR_W / DATA_W  game-logic write request, held until wr_ack_o.
REQ-007 wr_ack_o  output  1  one-cycle pulse: write committed.
REQ-008 rd_req_i / rd_addr_i  input  1 / ADDR_W  display/logic read request, held until rd_valid_o.
REQ-009 rd_data_o / rd_valid_o  output  DATA_W / 1  read result, valid for one cycle.
REQ-010 busy_o  output  1  high whenever FSM is not IDLE.
REQ-011 ram_wr_en_o / ram_rd_en_o  output  1 / 1  RAM-side strobes.
REQ-012 ram_addr_o  output  ADDR_W  RAM-side address.
REQ-013 ram_data_io  inout  DATA_W  shared RAM data bus.

Function
REQ-014 FSM states SHALL be IDLE, WRITE, READ_ADDR, READ_DATA, CLEAR.
REQ-015 IDLE arbitration SHALL be fixed priority clr_req_i > wr_req_i > rd_req_i; at most one transition per cycle.
REQ-016 WRITE: one cycle; ram_wr_en_o=1, ram_addr_o=wr_addr_i captured, bus driven with captured wr_data_i; wr_ack_o pulses in this cycle; next state IDLE.
REQ-017 READ_ADDR: ram_rd_en_o=1, ram_addr_o=captured rd_addr_i; next READ_DATA.
REQ-018 READ_DATA: ram_rd_en_o=1, same address; at end of cycle ram_data_io sampled into rd_data_o; rd_valid_o=1 the following cycle (IDLE); read latency = 3 cycles from acceptance to rd_valid_o.
REQ-019 CLEAR: 8-bit sweep counter from 0; each cycle ram_wr_en_o=1, ram_addr_o=counter, bus driven 0; exits to IDLE after address 255 (256 cycles exactly, no wrap to a second pass).
REQ-020 Master SHALL drive ram_data_io only in WRITE and CLEAR; otherwise high-Z; ram_wr_en_o and ram_rd_en_o SHALL never be high together.
REQ-021 Addresses/data SHALL be latched at acceptance; input changes during an operation SHALL not affect it.
REQ-022 A request deasserted before acceptance SHALL be dropped without ack.
REQ-023 Requests arriving while busy_o=1 SHALL wait; no queuing beyond the held request.
REQ-024 rd_data_o SHALL hold last read value until next read completes.
REQ-025 Back-to-back: after any operation FSM SHALL spend one IDLE cycle (bus turnaround) before the next.

Reset
REQ-026 When rst_n_i=0 at posedge: FSM=IDLE, counter=0, wr_ack_o=0, rd_valid_o=0, rd_data_o=0, ram_wr_en_o=0, ram_rd_en_o=0, ram_addr_o=0, bus high-Z, busy_o=0.
REQ-027 Reset mid-CLEAR or mid-READ SHALL abort immediately with no ack/valid pulse; partial clear not resumed.

Structure
REQ-028 State encoding, ADDR_W/DATA_W defaults and CLEAR_LAST=255 SHALL live in shared package ram_master_pkg.
REQ-029 Sweep counter SHALL be sub-module ram_sweep_cnt (enable, clear, last flag); rest flat.

Verification
REQ-030 Bench SHALL instantiate ram_master with the team's grid RAM behavioural model on one bus.
REQ-031 Write 0xA to 0x3C then read 0x3C -> wr_ack_o one pulse; rd_valid_o 3 cycles after read acceptance with rd_data_o=0xA.
REQ-032 clr_req_i, wr_req_i, rd_req_i raised same cycle -> CLEAR runs 256 cycles, then write acked, then read returns 0 at unwritten address.
REQ-033 After writing 0xF to 0x00 and 0xFF, CLEAR -> reads of 0x00, 0x80, 0xFF all return 0; busy_o high exactly 256 cycles.
REQ-034 rst_n_i low at clear cycle 100 -> all outputs per REQ-026 next cycle, no wr_ack_o/rd_valid_o.
REQ-035 Continuous bus monitor -> never ram_wr_en_o & ram_rd_en_o both 1; ram_data_io never X/contended in any test.
